// File: rtl/data_bus_responder_pkg.sv
// data_bus_responder_pkg: address map, STATUS layout and TX state encoding shared by the responder
package data_bus_responder_pkg;
   localparam logic [3:0] RAM_TAG = 4'h0;
   localparam logic [31:0] ADDR_TXDATA = 32'h1000_0000;
   localparam logic [31:0] ADDR_STATUS = 32'h1000_0004;
   localparam logic [31:0] ADDR_CTRL = 32'h1000_0008;
   localparam int ST_BUSY = 0;
   localparam int ST_FULL = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_COUNT = 3;
   localparam int ST_OVF = 6;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      START = 2'd1,
      DATA = 2'd2,
      STOP = 2'd3
   } tx_state_t;
endpackage

// File: rtl/data_bus_responder_uart_tx_core.sv
// uart_tx_core: TX FIFO plus 8N1 serialiser with a per-bit baud counter
module uart_tx_core
   import data_bus_responder_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = AW + 1
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic [7:0] push_data,
   output logic full,
   output logic empty,
   output logic [CW-1:0] count,
   output logic busy,
   output logic pop,
   output logic txd
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   logic [7:0] fifo [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic [BW-1:0] baud;
   logic [2:0] bit_idx;
   logic [7:0] shifter;
   logic baud_done, accept;
   tx_state_t state, state_n;
   assign full = cnt == CW'(FIFO_DEPTH);
   assign empty = cnt == '0;
   assign count = cnt;
   assign busy = state != IDLE;
   assign pop = state == IDLE && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign accept = push && (!full || pop);
   assign baud_done = baud == BW'(CLKS_PER_BIT - 1);
   assign txd = state == START ? 1'b0 : state == DATA ? shifter[0] : 1'b1;
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = pop ? START : IDLE;
         START: state_n = baud_done ? DATA : START;
         DATA: state_n = baud_done && bit_idx == 3'd7 ? STOP : DATA;
         STOP: state_n = baud_done ? IDLE : STOP;
      endcase
   end
   always_ff @(posedge clk)
      if (accept) fifo[wr_ptr] <= push_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt <= '0;
         baud <= '0;
         bit_idx <= '0;
         shifter <= '1;
      end else begin
         state <= state_n;
         wr_ptr <= wr_ptr + AW'(accept);
         rd_ptr <= rd_ptr + AW'(pop);
         cnt <= cnt + CW'(accept) - CW'(pop);
         baud <= (state_n != state || baud_done) ? '0 : baud + 1'b1;
         bit_idx <= state != DATA ? '0 : bit_idx + 3'(baud_done);
         shifter <= pop ? fifo[rd_ptr] : (state == DATA && baud_done) ? shifter >> 1 : shifter;
      end
   end
endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data-bus slave with byte-lane RAM and a memory-mapped UART transmitter
module data_bus_responder
   import data_bus_responder_pkg::*;
#(
   parameter int RAM_ADDR_W = 12,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
   input logic clk,
   input logic rst,
   input logic ce_i,
   input logic we_i,
   input logic [31:0] addr_i,
   input logic [3:0] sel_i,
   input logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic uart_txd_o,
   output logic uart_int_o
);
   logic [31:0] ram [2**RAM_ADDR_W];
   logic [RAM_ADDR_W-1:0] word_idx;
   logic [CW-1:0] count;
   logic [31:0] status;
   logic rd, wr, is_ram, push, ctrl_wr, full, empty, busy, pop, int_en, overflow;
   assign rd = ce_i && !we_i;
   assign wr = ce_i && we_i;
   assign is_ram = addr_i[31:28] == RAM_TAG;
   // bits above the RAM index are ignored, so the RAM aliases across the region
   assign word_idx = addr_i[RAM_ADDR_W+1:2];
   assign push = wr && addr_i == ADDR_TXDATA && |sel_i;
   assign ctrl_wr = wr && addr_i == ADDR_CTRL && sel_i[0];
   uart_tx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_tx (
      .clk(clk),
      .rst(rst),
      .push(push),
      .push_data(data_i[7:0]),
      .full(full),
      .empty(empty),
      .count(count),
      .busy(busy),
      .pop(pop),
      .txd(uart_txd_o)
   );
   always_ff @(posedge clk)
      if (wr && is_ram)
         for (int i = 0; i < 4; i++)
            if (sel_i[i]) ram[word_idx][8*i +: 8] <= data_i[8*i +: 8];
   always_ff @(posedge clk) begin
      if (rst) begin
         int_en <= 1'b0;
         overflow <= 1'b0;
         uart_int_o <= 1'b0;
      end else begin
         if (ctrl_wr) int_en <= data_i[0];
         overflow <= (ctrl_wr && data_i[1]) ? 1'b0 : overflow | (push && full && !pop);
         uart_int_o <= int_en && empty && !busy;
      end
   end
   always_comb begin
      status = '0;
      status[ST_BUSY] = busy;
      status[ST_FULL] = full;
      status[ST_EMPTY] = empty;
      status[ST_COUNT +: CW] = count;
      status[ST_OVF] = overflow;
   end
   assign data_o = !rd ? '0
                 : is_ram ? ram[word_idx]
                 : addr_i == ADDR_STATUS ? status
                 : addr_i == ADDR_CTRL ? {31'd0, int_en}
                 : '0;
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed scenario tests of RAM, UART framing, FIFO overflow, interrupt and reset
module tb_data_bus_responder;
   localparam logic [31:0] TXDATA = 32'h1000_0000;
   localparam logic [31:0] STATUS = 32'h1000_0004;
   localparam logic [31:0] CTRL = 32'h1000_0008;
   logic clk = 0, rst = 1, ce = 0, we = 0;
   logic [31:0] addr = 0, wdata = 0, rdata;
   logic [3:0] sel = 0;
   logic txd, irq;
   int cyc = 0, checks = 0, errors = 0;
   data_bus_responder dut (
      .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
      .data_i(wdata), .data_o(rdata), .uart_txd_o(txd), .uart_int_o(irq)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      ce = 1; we = 1; addr = a; wdata = d; sel = s;
      step();
      ce = 0; we = 0; sel = 0;
   endtask
   task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
      ce = 1; we = 0; addr = a;
      #1;
      r = rdata;
      ce = 0;
   endtask
   task automatic get_frame(input int base, output logic [9:0] f);
      for (int j = 0; j < 10; j++) begin
         wait_until(base + 16*j + 9);
         f[j] = txd;
      end
   endtask
   task automatic test_reset();
      logic [31:0] r;
      rst = 1;
      step(); step();
      rst = 0;
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", irq); end
      bus_read(STATUS, r);
      checks++; if (r !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 00000004", r); end
      bus_read(CTRL, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", r); end
   endtask
   task automatic test_ram_lanes();
      logic [31:0] r;
      bus_write(32'h10, 32'hAABBCCDD, 4'b1111);
      bus_read(32'h10, r);
      checks++; if (r !== 32'hAABBCCDD) begin errors++; $display("FAIL ram_full_word: got %h expected aabbccdd", r); end
      bus_write(32'h10, 32'h00000011, 4'b0001);
      bus_read(32'h10, r);
      checks++; if (r !== 32'hAABBCC11) begin errors++; $display("FAIL ram_lane0: got %h expected aabbcc11", r); end
      bus_write(32'h10, 32'h99887766, 4'b0000);
      bus_write(32'h14, 32'h12345678, 4'b1010);
      bus_write(32'h14, 32'hFFFFFFFF, 4'b0101);
      bus_read(32'h10, r);
      checks++; if (r !== 32'hAABBCC11) begin errors++; $display("FAIL ram_sel_zero: got %h expected aabbcc11", r); end
      bus_read(32'h14, r);
      checks++; if (r !== 32'h12FF56FF) begin errors++; $display("FAIL ram_mixed_lanes: got %h expected 12ff56ff", r); end
      bus_read(32'h0F00_4010, r);
      checks++; if (r !== 32'hAABBCC11) begin errors++; $display("FAIL ram_alias: got %h expected aabbcc11", r); end
      addr = 32'h10; ce = 0; #1;
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL read_ce_low: got %h expected 00000000", rdata); end
      ce = 1; we = 1; sel = 0; #1;
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL read_we_high: got %h expected 00000000", rdata); end
      ce = 0; we = 0;
      bus_read(TXDATA, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 00000000", r); end
   endtask
   task automatic test_single_frame();
      logic [31:0] r;
      logic [7:0] b = 8'h55;
      logic exp_txd;
      int bad = 0, first_bad = -1, busy_cnt = 0;
      step();
      bus_write(TXDATA, {24'd0, b}, 4'b0001);
      for (int k = 1; k <= 170; k++) begin
         step();
         bus_read(STATUS, r);
         busy_cnt += int'(r[0]);
         exp_txd = k <= 16 ? 1'b0 : k <= 144 ? b[(k-17)/16] : 1'b1;
         if (txd !== exp_txd) begin bad++; if (first_bad < 0) first_bad = k; end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL frame_trace: got %0d wrong cycles (first %0d) expected 0", bad, first_bad); end
      checks++; if (busy_cnt != 160) begin errors++; $display("FAIL frame_busy: got %0d cycles expected 160", busy_cnt); end
   endtask
   task automatic test_fifo_overflow();
      logic [31:0] r;
      logic [9:0] f;
      int c0;
      bus_write(TXDATA, 32'h01, 4'b0001);
      c0 = cyc;
      for (int i = 2; i <= 6; i++) bus_write(TXDATA, i, 4'b1000);
      bus_read(STATUS, r);
      checks++; if (r !== 32'h63) begin errors++; $display("FAIL ovf_status: got %h expected 00000063", r); end
      bus_write(CTRL, 32'h2, 4'b0001);
      bus_read(STATUS, r);
      checks++; if (r !== 32'h23) begin errors++; $display("FAIL ovf_cleared: got %h expected 00000023", r); end
      for (int n = 0; n < 5; n++) begin
         get_frame(c0 + 161*n, f);
         checks++;
         if (f !== {1'b1, 8'(n + 1), 1'b0}) begin
            errors++; $display("FAIL back_to_back_frame%0d: got %b expected %b", n, f, {1'b1, 8'(n + 1), 1'b0});
         end
      end
      wait_until(c0 + 5*161 + 5);
      bus_read(STATUS, r);
      checks++; if (r !== 32'h4) begin errors++; $display("FAIL drained_status: got %h expected 00000004", r); end
   endtask
   task automatic test_interrupt();
      logic [9:0] f;
      int c0;
      bus_write(CTRL, 32'h1, 4'b0001);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_before: got %b expected 0", irq); end
      step();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL int_enable: got %b expected 1", irq); end
      bus_write(TXDATA, 32'hA5, 4'b0001);
      c0 = cyc;
      step();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_push_drop: got %b expected 0", irq); end
      get_frame(c0, f);
      checks++; if (f !== {1'b1, 8'hA5, 1'b0}) begin errors++; $display("FAIL int_frame: got %b expected %b", f, {1'b1, 8'hA5, 1'b0}); end
      wait_until(c0 + 161);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_at_stop_end: got %b expected 0", irq); end
      wait_until(c0 + 162);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL int_rise: got %b expected 1", irq); end
      bus_write(CTRL, 32'h0, 4'b0001);
      step();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL int_disable: got %b expected 0", irq); end
   endtask
   task automatic test_reset_mid_frame();
      logic [31:0] r;
      int c0, lows = 0;
      bus_write(32'h40, 32'h12345678, 4'b1111);
      bus_write(CTRL, 32'h1, 4'b0001);
      bus_write(TXDATA, 32'h3C, 4'b0001);
      c0 = cyc;
      wait_until(c0 + 70);
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL pre_reset_bit3: got %b expected 1", txd); end
      rst = 1;
      step();
      rst = 0;
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_reset_txd: got %b expected 1", txd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_int: got %b expected 0", irq); end
      bus_read(STATUS, r);
      checks++; if (r !== 32'h4) begin errors++; $display("FAIL mid_reset_status: got %h expected 00000004", r); end
      bus_read(CTRL, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_reset_ctrl: got %h expected 00000000", r); end
      bus_read(32'h40, r);
      checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL mid_reset_ram: got %h expected 12345678", r); end
      for (int k = 0; k < 40; k++) begin step(); lows += int'(!txd); end
      checks++; if (lows != 0) begin errors++; $display("FAIL mid_reset_line_idle: got %0d low cycles expected 0", lows); end
   endtask
   task automatic test_unmapped();
      logic [31:0] r;
      int lows = 0;
      bus_write(32'h0, 32'h0BADF00D, 4'b1111);
      bus_write(32'h2000_0000, 32'hFFFFFFFF, 4'b1111);
      bus_write(32'h1000_000C, 32'hFFFFFFFF, 4'b1111);
      bus_read(32'h0, r);
      checks++; if (r !== 32'h0BADF00D) begin errors++; $display("FAIL unmapped_ram: got %h expected 0badf00d", r); end
      bus_read(32'h2000_0000, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 00000000", r); end
      bus_read(STATUS, r);
      checks++; if (r !== 32'h4) begin errors++; $display("FAIL unmapped_status: got %h expected 00000004", r); end
      for (int k = 0; k < 20; k++) begin step(); lows += int'(!txd); end
      checks++; if (lows != 0) begin errors++; $display("FAIL unmapped_line: got %0d low cycles expected 0", lows); end
   endtask
   initial begin
      test_reset();
      test_ram_lanes();
      test_single_frame();
      test_fifo_overflow();
      test_interrupt();
      test_reset_mid_frame();
      test_unmapped();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
